// File: rtl/lsu_pkg.sv
// Shared constants and FSM encoding for the queued load/store unit.
// The entry layout depends on instance widths, so the top declares it next to its parameters.
package lsu_pkg;

    localparam logic LSU_CMD_RD = 1'b0;
    localparam logic LSU_CMD_WR = 1'b1;

    localparam logic LSU_W_BYTE = 1'b0;
    localparam logic LSU_W_WORD = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BEAT0 = 2'd1,
        ST_BEAT1 = 2'd2
    } lsu_state_e;

endpackage

// File: rtl/lsu_rq_fifo.sv
// Request queue for the load/store unit: DEPTH entries, single clock, flush clears it in one cycle.
module lsu_rq_fifo #(
    parameter type entry_t = logic [7:0],
    parameter int  DEPTH   = 4
) (
    input  logic                   clk,
    input  logic                   a_rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  entry_t                 wr_entry,
    output entry_t                 rd_entry,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic               do_push;
    logic               do_pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push & ~full & ~flush;
    assign do_pop   = pop & ~empty & ~flush;
    assign rd_entry = mem[rd_ptr];

    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; the pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wr_entry;
    end

endmodule

// File: rtl/lsu_queued.sv
// Queued load/store unit: buffers tagged requests, drives the data-memory bus one beat at a time,
// splits misaligned word accesses into two beats and returns tagged responses in order.
module lsu_queued
    import lsu_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 4,
    parameter int TID_W  = 1
) (
    input  logic                clk,
    input  logic                a_rst,
    input  logic                rq_valid,
    output logic                rq_ready,
    input  logic [ADDR_W-1:0]   rq_addr,
    input  logic [DATA_W-1:0]   rq_data,
    input  logic                rq_width,
    input  logic                rq_cmd,
    input  logic [TID_W-1:0]    rq_t_id,
    input  logic                flush,
    input  logic                mem_rdy,
    input  logic [DATA_W-1:0]   mem_data_in,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_data,
    output logic [DATA_W/8-1:0] mem_be,
    output logic                mem_cmd,
    output logic                mem_bus_assert,
    output logic                rsp_valid,
    output logic                rsp_cmd,
    output logic [TID_W-1:0]    rsp_t_id,
    output logic [DATA_W-1:0]   rsp_data
);

    localparam int BYTES = DATA_W / 8;
    localparam int OFF_W = $clog2(BYTES);
    localparam logic [BYTES-1:0] ALL_BE = {BYTES{1'b1}};
    localparam logic [BYTES-1:0] ONE_BE = {{(BYTES-1){1'b0}}, 1'b1};

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              width;
        logic              cmd;
        logic [TID_W-1:0]  t_id;
    } entry_t;

    entry_t               in_entry, head, nxt, iss;
    logic [$clog2(DEPTH):0] count;
    logic                 full, empty, push, take, nxt_avail;
    logic                 beat_done, split_iss, finish;
    lsu_state_e           state;
    logic [DATA_W-1:0]    stage, rd_result, nxt_data, b1_data;
    logic [BYTES-1:0]     nxt_be, b1_be;
    logic [ADDR_W-1:0]    nxt_addr, b1_addr;
    logic [OFF_W-1:0]     nxt_off, iss_off;

    assign in_entry = '{addr: rq_addr, data: rq_data, width: rq_width, cmd: rq_cmd, t_id: rq_t_id};
    assign rq_ready = ~full;
    assign push     = rq_valid & rq_ready & ~flush;

    // An empty queue is bypassed so a push into an idle unit reaches the bus on the next cycle.
    assign nxt       = empty ? in_entry : head;
    assign nxt_avail = (~empty & ~flush) | push;

    assign iss_off   = iss.addr[OFF_W-1:0];
    assign split_iss = (iss.width == LSU_W_WORD) && (iss_off != '0);
    assign beat_done = mem_bus_assert & mem_rdy;
    assign finish    = beat_done & ((state == ST_BEAT1) | ((state == ST_BEAT0) & ~split_iss));
    assign take      = nxt_avail & ((state == ST_IDLE) | finish);

    lsu_rq_fifo #(.entry_t(entry_t), .DEPTH(DEPTH)) u_fifo (
        .clk      (clk),
        .a_rst    (a_rst),
        .push     (push & ~(take & empty)),
        .pop      (take & ~empty),
        .flush    (flush),
        .wr_entry (in_entry),
        .rd_entry (head),
        .count    (count),
        .full     (full),
        .empty    (empty)
    );

    assign nxt_off  = nxt.addr[OFF_W-1:0];
    assign nxt_addr = {nxt.addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign nxt_be   = (nxt.width == LSU_W_WORD) ? (ALL_BE << nxt_off) : (ONE_BE << nxt_off);
    assign nxt_data = (nxt.width == LSU_W_WORD) ? (nxt.data << (8 * nxt_off)) : {BYTES{nxt.data[7:0]}};

    // Second beat carries the high bytes of a misaligned word in the low lanes of the next word.
    assign b1_addr = {iss.addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}} + ADDR_W'(BYTES);
    assign b1_be   = ~(ALL_BE << iss_off);
    assign b1_data = iss.data >> (8 * (BYTES - int'(iss_off)));

    always_comb begin
        rd_result = mem_data_in;
        if (iss.width == LSU_W_BYTE)
            rd_result = (mem_data_in >> (8 * iss_off)) & DATA_W'(8'hFF);
        else if (split_iss)
            rd_result = (stage >> (8 * iss_off)) | (mem_data_in << (8 * (BYTES - int'(iss_off))));
    end

    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            state          <= ST_IDLE;
            iss            <= '0;
            stage          <= '0;
            mem_addr       <= '0;
            mem_data       <= '0;
            mem_be         <= '0;
            mem_cmd        <= 1'b0;
            mem_bus_assert <= 1'b0;
            rsp_valid      <= 1'b0;
            rsp_cmd        <= 1'b0;
            rsp_t_id       <= '0;
            rsp_data       <= '0;
        end else begin
            rsp_valid <= 1'b0;
            if (state == ST_BEAT0 && beat_done && split_iss) begin
                stage    <= mem_data_in;
                mem_addr <= b1_addr;
                mem_be   <= b1_be;
                mem_data <= b1_data;
                state    <= ST_BEAT1;
            end else begin
                if (finish) begin
                    rsp_valid <= 1'b1;
                    rsp_cmd   <= iss.cmd;
                    rsp_t_id  <= iss.t_id;
                    rsp_data  <= (iss.cmd == LSU_CMD_WR) ? '0 : rd_result;
                end
                if (take) begin
                    iss            <= nxt;
                    mem_addr       <= nxt_addr;
                    mem_be         <= nxt_be;
                    mem_data       <= nxt_data;
                    mem_cmd        <= nxt.cmd;
                    mem_bus_assert <= 1'b1;
                    state          <= ST_BEAT0;
                end else if (finish) begin
                    mem_bus_assert <= 1'b0;
                    state          <= ST_IDLE;
                end
            end
        end
    end

endmodule

// File: tb/tb_lsu_queued.sv
// Directed self-checking bench for lsu_queued: a 16-bit instance and a 32-bit instance.
module tb_lsu_queued;

    logic        clk = 1'b0;
    logic        a_rst;
    int          checks = 0;
    int          failures = 0;

    logic        rq_valid, rq_ready, rq_width, rq_cmd, flush, mem_rdy;
    logic [15:0] rq_addr, rq_data, mem_data_in, mem_addr, mem_data, rsp_data;
    logic [1:0]  mem_be;
    logic [0:0]  rq_t_id, rsp_t_id;
    logic        mem_cmd, mem_bus_assert, rsp_valid, rsp_cmd;

    logic        rq_valid_w, rq_ready_w, rq_width_w, rq_cmd_w, flush_w, mem_rdy_w;
    logic [15:0] rq_addr_w, mem_addr_w;
    logic [31:0] rq_data_w, mem_data_in_w, mem_data_w, rsp_data_w;
    logic [3:0]  mem_be_w;
    logic [0:0]  rq_t_id_w, rsp_t_id_w;
    logic        mem_cmd_w, mem_bus_assert_w, rsp_valid_w, rsp_cmd_w;

    always #5 clk = ~clk;

    lsu_queued #(.DATA_W(16), .ADDR_W(16), .DEPTH(4), .TID_W(1)) dut (
        .clk(clk), .a_rst(a_rst), .rq_valid(rq_valid), .rq_ready(rq_ready),
        .rq_addr(rq_addr), .rq_data(rq_data), .rq_width(rq_width), .rq_cmd(rq_cmd),
        .rq_t_id(rq_t_id), .flush(flush), .mem_rdy(mem_rdy), .mem_data_in(mem_data_in),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_be(mem_be), .mem_cmd(mem_cmd),
        .mem_bus_assert(mem_bus_assert), .rsp_valid(rsp_valid), .rsp_cmd(rsp_cmd),
        .rsp_t_id(rsp_t_id), .rsp_data(rsp_data)
    );

    lsu_queued #(.DATA_W(32), .ADDR_W(16), .DEPTH(4), .TID_W(1)) dut_w (
        .clk(clk), .a_rst(a_rst), .rq_valid(rq_valid_w), .rq_ready(rq_ready_w),
        .rq_addr(rq_addr_w), .rq_data(rq_data_w), .rq_width(rq_width_w), .rq_cmd(rq_cmd_w),
        .rq_t_id(rq_t_id_w), .flush(flush_w), .mem_rdy(mem_rdy_w), .mem_data_in(mem_data_in_w),
        .mem_addr(mem_addr_w), .mem_data(mem_data_w), .mem_be(mem_be_w), .mem_cmd(mem_cmd_w),
        .mem_bus_assert(mem_bus_assert_w), .rsp_valid(rsp_valid_w), .rsp_cmd(rsp_cmd_w),
        .rsp_t_id(rsp_t_id_w), .rsp_data(rsp_data_w)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic set_request(input logic [15:0] addr, input logic [15:0] data,
                               input logic width, input logic cmd, input logic tid);
        rq_valid = 1'b1;
        rq_addr  = addr;
        rq_data  = data;
        rq_width = width;
        rq_cmd   = cmd;
        rq_t_id  = tid;
    endtask

    initial begin
        a_rst = 1'b1;
        rq_valid = 0; rq_addr = 0; rq_data = 0; rq_width = 0; rq_cmd = 0; rq_t_id = 0;
        flush = 0; mem_rdy = 1; mem_data_in = 0;
        rq_valid_w = 0; rq_addr_w = 0; rq_data_w = 0; rq_width_w = 0; rq_cmd_w = 0; rq_t_id_w = 0;
        flush_w = 0; mem_rdy_w = 1; mem_data_in_w = 0;
        tick();
        tick();

        check_output("reset_rq_ready", rq_ready, 1);
        check_output("reset_bus_assert", mem_bus_assert, 0);
        check_output("reset_rsp_valid", rsp_valid, 0);
        check_output("reset_be", mem_be, 0);
        check_output("reset_addr", mem_addr, 0);
        a_rst = 1'b0;
        tick();

        // Aligned word read: bus at N+1, response at N+2.
        set_request(16'h0010, 16'h0000, 1'b1, 1'b0, 1'b1);
        mem_data_in = 16'hBEEF;
        tick();
        rq_valid = 1'b0;
        check_output("rd_word_assert", mem_bus_assert, 1);
        check_output("rd_word_addr", mem_addr, 16'h0010);
        check_output("rd_word_be", mem_be, 2'b11);
        check_output("rd_word_cmd", mem_cmd, 0);
        check_output("rd_word_no_early_rsp", rsp_valid, 0);
        tick();
        check_output("rd_word_rsp_valid", rsp_valid, 1);
        check_output("rd_word_rsp_data", rsp_data, 16'hBEEF);
        check_output("rd_word_rsp_tid", rsp_t_id, 1);
        check_output("rd_word_rsp_cmd", rsp_cmd, 0);
        check_output("rd_word_idle", mem_bus_assert, 0);
        tick();
        check_output("rd_word_rsp_pulse", rsp_valid, 0);

        // Misaligned word write splits into two beats with one response.
        set_request(16'h0011, 16'hA1B2, 1'b1, 1'b1, 1'b0);
        tick();
        rq_valid = 1'b0;
        check_output("wr_split_b0_addr", mem_addr, 16'h0010);
        check_output("wr_split_b0_be", mem_be, 2'b10);
        check_output("wr_split_b0_data", mem_data, 16'hB200);
        check_output("wr_split_b0_cmd", mem_cmd, 1);
        tick();
        check_output("wr_split_b1_assert", mem_bus_assert, 1);
        check_output("wr_split_b1_addr", mem_addr, 16'h0012);
        check_output("wr_split_b1_be", mem_be, 2'b01);
        check_output("wr_split_b1_data", mem_data, 16'h00A1);
        check_output("wr_split_b1_no_rsp", rsp_valid, 0);
        tick();
        check_output("wr_split_rsp_valid", rsp_valid, 1);
        check_output("wr_split_rsp_cmd", rsp_cmd, 1);
        check_output("wr_split_rsp_data", rsp_data, 0);
        check_output("wr_split_idle", mem_bus_assert, 0);
        tick();

        // Byte read from the upper lane, zero-extended.
        set_request(16'h0023, 16'h0000, 1'b0, 1'b0, 1'b0);
        mem_data_in = 16'h5A00;
        tick();
        rq_valid = 1'b0;
        check_output("rd_byte_addr", mem_addr, 16'h0022);
        check_output("rd_byte_be", mem_be, 2'b10);
        tick();
        check_output("rd_byte_rsp_valid", rsp_valid, 1);
        check_output("rd_byte_rsp_data", rsp_data, 16'h005A);
        tick();

        // Stalled bus: one request in the issue register, four queued, the sixth is refused.
        mem_rdy = 1'b0;
        mem_data_in = 16'h0000;
        for (int i = 0; i < 6; i++) begin
            set_request(16'h0100 + 16'(2 * i), 16'h0000, 1'b1, 1'b0, 1'(i));
            check_output($sformatf("stall_ready_%0d", i), rq_ready, (i < 5) ? 1 : 0);
            tick();
        end
        rq_valid = 1'b0;
        check_output("stall_full", rq_ready, 0);
        check_output("stall_held_addr", mem_addr, 16'h0100);
        mem_rdy = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check_output($sformatf("drain_addr_%0d", k), mem_addr, 16'h0100 + 16'(2 * k));
            tick();
            check_output($sformatf("drain_rsp_%0d", k), rsp_valid, 1);
            check_output($sformatf("drain_tid_%0d", k), rsp_t_id, 32'(k % 2));
        end
        check_output("drain_done", mem_bus_assert, 0);
        check_output("drain_ready", rq_ready, 1);
        tick();
        check_output("drain_no_extra_rsp", rsp_valid, 0);

        // Flush while a split read sits in beat0 with three queued behind it.
        mem_rdy = 1'b0;
        set_request(16'h0031, 16'h0000, 1'b1, 1'b0, 1'b1);
        tick();
        for (int i = 0; i < 3; i++) begin
            set_request(16'h0040 + 16'(2 * i), 16'h0000, 1'b1, 1'b0, 1'b0);
            tick();
        end
        rq_valid = 1'b0;
        check_output("flush_pre_addr", mem_addr, 16'h0030);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_output("flush_ready", rq_ready, 1);
        mem_rdy = 1'b1;
        mem_data_in = 16'h3300;
        tick();
        check_output("flush_b1_addr", mem_addr, 16'h0032);
        check_output("flush_b1_be", mem_be, 2'b01);
        mem_data_in = 16'h0044;
        tick();
        check_output("flush_rsp_valid", rsp_valid, 1);
        check_output("flush_rsp_data", rsp_data, 16'h4433);
        check_output("flush_rsp_tid", rsp_t_id, 1);
        check_output("flush_no_more_beats", mem_bus_assert, 0);
        tick();
        check_output("flush_still_idle", mem_bus_assert, 0);
        check_output("flush_single_rsp", rsp_valid, 0);

        // Reset in the middle of beat1 drops the bus at once and loses the request.
        set_request(16'h0051, 16'h1122, 1'b1, 1'b1, 1'b0);
        tick();
        rq_valid = 1'b0;
        tick();
        check_output("rst_mid_b1_be", mem_be, 2'b01);
        a_rst = 1'b1;
        #1;
        check_output("rst_mid_bus_drop", mem_bus_assert, 0);
        tick();
        a_rst = 1'b0;
        check_output("rst_mid_no_rsp", rsp_valid, 0);
        tick();
        check_output("rst_after_no_rsp", rsp_valid, 0);
        set_request(16'h0060, 16'h0000, 1'b1, 1'b0, 1'b1);
        mem_data_in = 16'h1234;
        tick();
        rq_valid = 1'b0;
        check_output("rst_next_assert", mem_bus_assert, 1);
        check_output("rst_next_addr", mem_addr, 16'h0060);
        tick();
        check_output("rst_next_rsp", rsp_valid, 1);
        check_output("rst_next_data", rsp_data, 16'h1234);

        // 32-bit instance: misaligned write, then a read whose second beat wraps to address 0.
        rq_valid_w = 1'b1; rq_addr_w = 16'h0003; rq_data_w = 32'h44332211;
        rq_width_w = 1'b1; rq_cmd_w = 1'b1; rq_t_id_w = 1'b0;
        tick();
        rq_valid_w = 1'b0;
        check_output("w32_b0_addr", mem_addr_w, 16'h0000);
        check_output("w32_b0_be", mem_be_w, 4'b1000);
        check_output("w32_b0_data", mem_data_w, 32'h11000000);
        tick();
        check_output("w32_b1_addr", mem_addr_w, 16'h0004);
        check_output("w32_b1_be", mem_be_w, 4'b0111);
        check_output("w32_b1_data", mem_data_w, 32'h00443322);
        tick();
        check_output("w32_rsp_valid", rsp_valid_w, 1);
        rq_valid_w = 1'b1; rq_addr_w = 16'hFFFD; rq_data_w = 32'h0;
        rq_width_w = 1'b1; rq_cmd_w = 1'b0; rq_t_id_w = 1'b1;
        mem_data_in_w = 32'hCCBBAA00;
        tick();
        rq_valid_w = 1'b0;
        check_output("r32_b0_addr", mem_addr_w, 16'hFFFC);
        check_output("r32_b0_be", mem_be_w, 4'b1110);
        tick();
        check_output("r32_b1_wrap_addr", mem_addr_w, 16'h0000);
        check_output("r32_b1_be", mem_be_w, 4'b0001);
        mem_data_in_w = 32'h000000DD;
        tick();
        check_output("r32_rsp_valid", rsp_valid_w, 1);
        check_output("r32_rsp_data", rsp_data_w, 32'hDDCCBBAA);
        check_output("r32_rsp_tid", rsp_t_id_w, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
